// File: rtl/ssp_frame_pkg.sv
// Shared state type and frame-geometry helpers for the SSP frame slave.
package ssp_frame_pkg;

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    function automatic int unsigned hdr_len(input int unsigned ch_w, input int unsigned ra_w);
        return ch_w + ra_w + 1;
    endfunction

    function automatic int unsigned frm_len(input int unsigned ch_w, input int unsigned ra_w,
                                            input int unsigned data_w);
        return hdr_len(ch_w, ra_w) + data_w;
    endfunction

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_par(input logic [31:0] x);
        return ~^x;
    endfunction

endpackage

// File: rtl/ssp_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered rise/fall pulses
// (three Clk cycles from pin change to pulse).
module ssp_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic ff1;
    logic ff2;
    logic ff3;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1  <= RST_VAL;
            ff2  <= RST_VAL;
            ff3  <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            ff1  <= din;
            ff2  <= ff1;
            ff3  <= ff2;
            rise <= ff2 & ~ff3;
            fall <= ~ff2 & ff3;
        end
    end

endmodule

// File: rtl/ssp_frame_slave.sv
// SPI-mode-0 SSP frame slave: CH|RA|WnR|DATA frames become register write strobes and
// read requests on Clk. Optional odd-parity bit after DATA is enabled by SSP_PARITY_EN.
module ssp_frame_slave
    import ssp_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned CH_W   = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SSP_SSEL,
    input  logic              SSP_SCK,
    input  logic              SSP_MOSI,
    output logic              SSP_MISO,
    output logic              SSP_OE,
    output logic [CH_W-1:0]   Reg_Ch,
    output logic [RA_W-1:0]   Reg_RA,
    output logic              Reg_WnR,
    output logic              Hdr_Vld,
    output logic              Rd_Req,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Wr_Stb,
    output logic [DATA_W-1:0] Wr_Data,
`ifdef SSP_PARITY_EN
    output logic              Par_Err,
`endif
    output logic              Abort
);

`ifdef SSP_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned HDR_LEN = hdr_len(CH_W, RA_W);
    localparam int unsigned END_LEN = frm_len(CH_W, RA_W, DATA_W) + PAR_W;
    localparam int unsigned CNT_W   = $clog2(END_LEN + 1);
    localparam int unsigned TX_W    = DATA_W + PAR_W;
    localparam int unsigned RX_W    = (HDR_LEN > TX_W) ? HDR_LEN : TX_W;

    logic              ssel_rise, ssel_fall, sck_rise, sck_fall;
    logic [2:0]        mosi_pipe;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [RX_W-2:0]   rx_sr, rx_nxt;
    logic [RX_W-1:0]   rx_shift;
    logic [TX_W-1:0]   tx_sr, tx_nxt;
    logic              rd_ld, miso_nxt, oe_nxt, wnr_nxt, hdr_vld_nxt, rd_req_nxt;
    logic              wr_stb_nxt, abort_nxt, par_err_nxt;
    logic [CH_W-1:0]   ch_nxt;
    logic [RA_W-1:0]   ra_nxt;
    logic [DATA_W-1:0] wr_data_nxt;
    logic              par_err_q;

    ssp_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk (Clk), .rst (Rst), .din (SSP_SSEL), .rise (ssel_rise), .fall (ssel_fall)
    );

    ssp_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk (Clk), .rst (Rst), .din (SSP_SCK), .rise (sck_rise), .fall (sck_fall)
    );

    // MOSI gets three stages so its level lines up with the SCK edge pulses.
    assign rx_shift = {rx_sr, mosi_pipe[2]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mosi_pipe <= '0;
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rd_ld     <= 1'b0;
            SSP_MISO  <= 1'b0;
            SSP_OE    <= 1'b0;
            Reg_Ch    <= '0;
            Reg_RA    <= '0;
            Reg_WnR   <= 1'b0;
            Hdr_Vld   <= 1'b0;
            Rd_Req    <= 1'b0;
            Wr_Stb    <= 1'b0;
            Wr_Data   <= '0;
            Abort     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            mosi_pipe <= {mosi_pipe[1:0], SSP_MOSI};
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            rx_sr     <= rx_nxt;
            tx_sr     <= tx_nxt;
            rd_ld     <= Rd_Req;
            SSP_MISO  <= miso_nxt;
            SSP_OE    <= oe_nxt;
            Reg_Ch    <= ch_nxt;
            Reg_RA    <= ra_nxt;
            Reg_WnR   <= wnr_nxt;
            Hdr_Vld   <= hdr_vld_nxt;
            Rd_Req    <= rd_req_nxt;
            Wr_Stb    <= wr_stb_nxt;
            Wr_Data   <= wr_data_nxt;
            Abort     <= abort_nxt;
            par_err_q <= par_err_nxt;
        end
    end

`ifdef SSP_PARITY_EN
    assign Par_Err = par_err_q;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        rx_nxt      = rx_sr;
        tx_nxt      = tx_sr;
        miso_nxt    = SSP_MISO;
        oe_nxt      = SSP_OE;
        ch_nxt      = Reg_Ch;
        ra_nxt      = Reg_RA;
        wnr_nxt     = Reg_WnR;
        hdr_vld_nxt = Hdr_Vld;
        rd_req_nxt  = 1'b0;
        wr_stb_nxt  = 1'b0;
        wr_data_nxt = Wr_Data;
        abort_nxt   = 1'b0;
        par_err_nxt = 1'b0;

        if (ssel_fall) oe_nxt = 1'b1;
        if (ssel_rise) oe_nxt = 1'b0;

        // Read data arrives the cycle after Rd_Req; parity (if any) trails the data bits.
        if (rd_ld) begin
`ifdef SSP_PARITY_EN
            tx_nxt = {Rd_Data, odd_par(32'(Rd_Data))};
`else
            tx_nxt = Rd_Data;
`endif
        end

        unique case (state)
            IDLE: begin
                miso_nxt = 1'b0;
                if (ssel_fall) begin
                    state_nxt = HDR;
                    cnt_nxt   = '0;
                    rx_nxt    = '0;
                    tx_nxt    = '0;
                end
            end
            HDR: begin
                miso_nxt = 1'b0;
                if (sck_rise) begin
                    rx_nxt  = rx_shift[RX_W-2:0];
                    cnt_nxt = bit_cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(HDR_LEN)) begin
                        state_nxt   = DATA;
                        ch_nxt      = rx_shift[HDR_LEN-1 -: CH_W];
                        ra_nxt      = rx_shift[RA_W:1];
                        wnr_nxt     = rx_shift[0];
                        hdr_vld_nxt = 1'b1;
                        rd_req_nxt  = ~rx_shift[0];
                    end
                end
            end
            DATA: begin
                if (sck_fall) begin
                    miso_nxt = tx_sr[TX_W-1];
                    tx_nxt   = tx_sr << 1;
                end
                if (sck_rise) begin
                    rx_nxt  = rx_shift[RX_W-2:0];
                    cnt_nxt = bit_cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(END_LEN)) begin
                        state_nxt = DONE;
                        if (Reg_WnR) begin
`ifdef SSP_PARITY_EN
                            if (^rx_shift[DATA_W:0]) begin
                                wr_stb_nxt  = 1'b1;
                                wr_data_nxt = rx_shift[DATA_W:1];
                            end else begin
                                abort_nxt   = 1'b1;
                                par_err_nxt = 1'b1;
                                hdr_vld_nxt = 1'b0;
                            end
`else
                            wr_stb_nxt  = 1'b1;
                            wr_data_nxt = rx_shift[DATA_W-1:0];
`endif
                        end
                    end
                end
            end
            DONE: begin
                // Surplus SCK edges are ignored and MISO keeps its last bit.
            end
        endcase

        // An SCK edge in the same cycle wins, so a just-completed frame is not aborted.
        if (ssel_rise && state != IDLE) begin
            hdr_vld_nxt = 1'b0;
            rd_req_nxt  = 1'b0;
            if (state_nxt != DONE) abort_nxt = 1'b1;
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_ssp_frame_slave.sv
// Scoreboard bench for ssp_frame_slave: an SPI master task drives frames, expected
// strobes are queued per frame and a monitor pops them as the DUT pulses.
module tb_ssp_frame_slave;

    localparam int unsigned DW = 12;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 2;
    localparam int unsigned HL = CW + RW + 1;
`ifdef SSP_PARITY_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned FL = HL + DW + PW;
    localparam int unsigned TW = DW + PW;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_AB = 2;
    localparam int K_PE = 3;

    typedef struct {
        int            kind;
        logic [CW-1:0] ch;
        logic [RW-1:0] ra;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_bad = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ssel = 1'b1;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          miso, oe, reg_wnr, hdr_vld, rd_req, wr_stb, abort;
    logic [CW-1:0] reg_ch;
    logic [RW-1:0] reg_ra;
    logic [DW-1:0] wr_data;
`ifdef SSP_PARITY_EN
    logic          par_err;
`endif

    ssp_frame_slave #(.DATA_W(DW), .RA_W(RW), .CH_W(CW)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .SSP_SSEL (ssel),
        .SSP_SCK  (sck),
        .SSP_MOSI (mosi),
        .SSP_MISO (miso),
        .SSP_OE   (oe),
        .Reg_Ch   (reg_ch),
        .Reg_RA   (reg_ra),
        .Reg_WnR  (reg_wnr),
        .Hdr_Vld  (hdr_vld),
        .Rd_Req   (rd_req),
        .Rd_Data  (rd_data),
        .Wr_Stb   (wr_stb),
        .Wr_Data  (wr_data),
`ifdef SSP_PARITY_EN
        .Par_Err  (par_err),
`endif
        .Abort    (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI mode-0 frame of nbits bits (SCK = clk/10); expectations queued first.
    task automatic frame(input logic [CW-1:0] ch, input logic [RW-1:0] ra, input logic wnr,
                         input logic [DW-1:0] data, input int nbits, input bit flip,
                         input bit release_ssel);
        logic [FL-1:0] frm;
        logic [TW-1:0] exp_tx;
        logic [31:0]   mw;
        ev_t           e;
        frm[FL-1 -: HL+DW]    = {ch, ra, wnr, data};
        exp_tx[TW-1 -: DW]    = wnr ? '0 : rd_data;
`ifdef SSP_PARITY_EN
        frm[0]    = (~^data) ^ flip;
        exp_tx[0] = wnr ? 1'b0 : ~^rd_data;
`endif
        e.ch = ch; e.ra = ra; e.data = data;
        if (!wnr && nbits >= int'(HL)) begin e.kind = K_RD; exp_q.push_back(e); end
        if (release_ssel) begin
            if (nbits < int'(FL)) begin
                e.kind = K_AB; exp_q.push_back(e);
            end else if (wnr) begin
                e.kind = (PW == 1 && flip) ? K_PE : K_WR; exp_q.push_back(e);
            end
        end
        ssel = 1'b0;
        #50;
        mw = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = frm[FL-1-i];
            #50;
            if (i >= int'(HL)) mw = {mw[30:0], miso};
            if (i == 2) chk("ssp_oe_in_frame", 32'(oe), 32'd1);
            sck = 1'b1;
            #50;
            sck = 1'b0;
        end
        #50;
        if (release_ssel) begin
            ssel = 1'b0 | 1'b1;
            mosi = 1'b0;
            if (nbits == int'(FL)) chk("miso_word", mw, 32'(exp_tx));
            #200;
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (!rst && (wr_stb || rd_req || abort)) begin
            k = wr_stb ? K_WR : (rd_req ? K_RD : K_AB);
`ifdef SSP_PARITY_EN
            if (abort && par_err) k = K_PE;
`endif
            chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                if (k == K_WR) begin
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    chk("wr_ch", 32'(reg_ch), 32'(e.ch));
                    chk("wr_ra", 32'(reg_ra), 32'(e.ra));
                    chk("wr_wnr", 32'(reg_wnr), 32'd1);
                end else if (k == K_RD) begin
                    chk("rd_ch", 32'(reg_ch), 32'(e.ch));
                    chk("rd_ra", 32'(reg_ra), 32'(e.ra));
                    chk("rd_wnr", 32'(reg_wnr), 32'd0);
                    chk("rd_hdr_vld", 32'(hdr_vld), 32'd1);
                end else begin
                    chk("abort_hdr_vld", 32'(hdr_vld), 32'd0);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  flip;
        logic w;
        repeat (5) @(negedge clk);
        chk("rst_hold_outputs", {20'(wr_data), 2'(reg_ch), 3'(reg_ra), reg_wnr, hdr_vld,
                                 rd_req, wr_stb, abort, oe, miso}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_hdr_vld", 32'(hdr_vld), 32'd0);
        chk("post_rst_miso", 32'(miso), 32'd0);
        chk("post_rst_oe", 32'(oe), 32'd0);

        // Directed: write, read, short frame then recovery.
        frame(2'd2, 3'd5, 1'b1, 12'hA5C, FL, 1'b0, 1'b1);
        rd_data = 12'h3C1;
        frame(2'd1, 3'd3, 1'b0, 12'h000, FL, 1'b0, 1'b1);
        frame(2'd3, 3'd6, 1'b1, 12'h123, 9, 1'b0, 1'b1);
        chk("hdr_vld_after_abort", 32'(hdr_vld), 32'd0);
        frame(2'd3, 3'd6, 1'b1, 12'h123, FL, 1'b0, 1'b1);

        // Reset during the data phase of a write frame.
        frame(2'd1, 3'd2, 1'b1, 12'h555, 12, 1'b0, 1'b0);
        chk("hdr_vld_mid_frame", 32'(hdr_vld), 32'd1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        ssel = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_frame_rst_outputs", {20'(wr_data), 2'(reg_ch), 3'(reg_ra), reg_wnr, hdr_vld,
                                      rd_req, wr_stb, abort, oe, miso}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        frame(2'd0, 3'd0, 1'b1, 12'h001, FL, 1'b0, 1'b1);

        // Back-to-back all-ones / all-zeros writes.
        frame(2'd3, 3'd7, 1'b1, 12'hFFF, FL, 1'b0, 1'b1);
        frame(2'd0, 3'd1, 1'b1, 12'h000, FL, 1'b0, 1'b1);
`ifdef SSP_PARITY_EN
        frame(2'd2, 3'd4, 1'b1, 12'h7FF, FL, 1'b1, 1'b1);
        frame(2'd2, 3'd4, 1'b1, 12'h7FF, FL, 1'b0, 1'b1);
`endif

        // Random traffic including truncated frames.
        for (int t = 0; t < 40; t++) begin
            rd_data = DW'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : int'(FL);
            flip = (PW == 1) && ($urandom_range(0, 3) == 0);
            w = 1'($urandom);
            frame(CW'($urandom), RW'($urandom), w, DW'($urandom), n, flip, 1'b1);
        end

        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
